// File: rtl/result_display.sv
// Captures signed CPU results, converts them to BCD with a sequential double-dabble
// engine and scans them onto an 8-digit seven-segment display. Option: LEADING_ZERO_BLANK_EN.
module result_display #(
    parameter int DATA_WIDTH  = 16,
    parameter int BCD_DIGITS  = 5,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] result,
    input  logic                         valid_result,
    input  logic                         error,
    input  logic                         halt,
    output logic                         busy,
    output logic [7:0]                   an,
    output logic [6:0]                   seg,
    output logic                         dp
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int REF_W = $clog2(REFRESH_DIV + 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                         state, state_next;
    logic [CNT_W-1:0]               bit_cnt;
    logic [DATA_WIDTH-1:0]          mag;
    logic [BCD_W-1:0]               bcd;
    logic                           sign;
    logic                           pend_vld;
    logic signed [DATA_WIDTH-1:0]   pend_data;
    logic [BCD_W-1:0]               disp_bcd;
    logic                           disp_neg;
    logic                           err_flag;
    logic                           start;
    logic signed [DATA_WIDTH-1:0]   start_val;
    logic [REF_W-1:0]               refresh_cnt;
    logic [2:0]                     digit_idx;
    logic [6:0]                     seg_next;

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] u;
        u = v;
        return v[DATA_WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Active-low segments, a on bit 0 through g on bit 6.
    function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // A new conversion starts from IDLE on a fresh result, or directly out of COMMIT
    // when a result is waiting; the newest arrival always wins.
    assign start     = ((state == IDLE) && valid_result) ||
                       ((state == COMMIT) && (valid_result || pend_vld));
    assign start_val = valid_result ? result : pend_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_result) state_next = SHIFT;
            SHIFT:   if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = (valid_result || pend_vld) ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            pend_vld <= 1'b0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            err_flag <= err_flag | error;
            if (start)
                bit_cnt <= '0;
            else if (state == SHIFT)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == COMMIT)
                pend_vld <= 1'b0;
            else if ((state == SHIFT) && valid_result)
                pend_vld <= 1'b1;
            if (state == COMMIT) begin
                disp_bcd <= bcd;
                disp_neg <= sign;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid_result && (state != IDLE))
            pend_data <= result;
        if (start) begin
            mag  <= abs_val(start_val);
            sign <= start_val[DATA_WIDTH-1];
            bcd  <= '0;
        end else if (state == SHIFT) begin
            {bcd, mag} <= {dabble_adj(bcd), mag} << 1;
        end
    end

    // Digit content for the slot currently being scanned.
    always_comb begin
        int top;
        seg_next = SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
        top = 0;
        for (int j = 0; j < BCD_DIGITS; j++) begin
            if (disp_bcd[4*j +: 4] != 4'd0)
                top = j;
        end
`else
        top = BCD_DIGITS - 1;
`endif
        if (err_flag) begin
            case (digit_idx)
                3'd0, 3'd1: seg_next = SEG_R;
                3'd2:       seg_next = SEG_E;
                default:    seg_next = SEG_BLANK;
            endcase
        end else begin
            for (int j = 0; j < BCD_DIGITS; j++) begin
                if ((int'(digit_idx) == j) && (j <= top))
                    seg_next = seg_of_digit(disp_bcd[4*j +: 4]);
            end
            if (disp_neg && (int'(digit_idx) == top + 1))
                seg_next = SEG_MINUS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= 8'hFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an  <= ~(8'd1 << digit_idx);
            seg <= seg_next;
            dp  <= ~(halt && (digit_idx == 3'd7));
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: scan order, BCD conversion, pending overwrite,
// error/halt display and asynchronous reset, with a fast refresh divider.
module tb_result_display;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] result;
    logic               valid_result;
    logic               error;
    logic               halt;
    logic               busy;
    logic [7:0]         an;
    logic [6:0]         seg;
    logic               dp;

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_d [0:7];

    always #5 clk = ~clk;

    result_display #(
        .DATA_WIDTH (16),
        .BCD_DIGITS (5),
        .REFRESH_DIV(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .result      (result),
        .valid_result(valid_result),
        .error       (error),
        .halt        (halt),
        .busy        (busy),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_digit(input string tag, input int idx, input logic [6:0] expv);
        logic [7:0] tgt;
        tgt = ~(8'd1 << idx);
        for (int t = 0; t < 40 && an !== tgt; t++) @(negedge clk);
        check({tag, "_an"}, {24'd0, an}, {24'd0, tgt});
        check(tag, {25'd0, seg}, {25'd0, expv});
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 8; i++)
            check_digit($sformatf("%s_d%0d", name, i), i, exp_d[i]);
    endtask

    // Returns at the negedge following the edge that sampled valid_result.
    task automatic start_conv(input logic signed [15:0] v);
        @(negedge clk);
        result       = v;
        valid_result = 1'b1;
        @(negedge clk);
        valid_result = 1'b0;
    endtask

    initial begin
        logic [6:0] exp_seg;
        logic       busy_ok;
        logic       saw8;
        int         idx;

        reset = 1'b1; valid_result = 1'b0; error = 1'b0; halt = 1'b0; result = '0;
        repeat (2) @(negedge clk);
        check("rst_an",   {24'd0, an},  32'hFF);
        check("rst_seg",  {25'd0, seg}, 32'h7F);
        check("rst_dp",   {31'd0, dp},  32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Idle scan of the reset value +0.
        reset = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            idx = ((n - 1) / 4) % 8;
`ifdef LEADING_ZERO_BLANK_EN
            exp_seg = (idx == 0) ? 7'h40 : 7'h7F;
`else
            exp_seg = (idx < 5) ? 7'h40 : 7'h7F;
`endif
            check($sformatf("scan_an_%0d", n),  {24'd0, an},  {24'd0, ~(8'd1 << idx)});
            check($sformatf("scan_seg_%0d", n), {25'd0, seg}, {25'd0, exp_seg});
        end
        check("idle_busy", {31'd0, busy}, 32'd0);

        // -123: busy window and display.
        start_conv(-16'sd123);
        check("neg123_busy_k1", {31'd0, busy}, 32'd1);
        repeat (16) @(negedge clk);
        check("neg123_busy_k17", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("neg123_busy_end", {31'd0, busy}, 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        exp_d = '{7'h30, 7'h24, 7'h79, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        exp_d = '{7'h30, 7'h24, 7'h79, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F};
`endif
        check_all("neg123");

        // Back-to-back 7, 8, 9 aligned so digit 0 is scanned while 7 is displayed.
        for (int t = 0; t < 40 && an !== 8'hFD; t++) @(negedge clk);
        for (int t = 0; t < 40 && an !== 8'hFE; t++) @(negedge clk);
        check("b2b_align", {24'd0, an}, 32'hFE);
        busy_ok = 1'b1;
        saw8    = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (n >= 8 && n <= 41 && busy !== 1'b1) busy_ok = 1'b0;
            if (n == 42) check("b2b_busy_end", {31'd0, busy}, 32'd0);
            if (an === 8'hFE && seg === 7'h00) saw8 = 1'b1;
            if (n == 33) begin
                check("b2b_show7_an",  {24'd0, an},  32'hFE);
                check("b2b_show7_seg", {25'd0, seg}, 32'h78);
            end
            if (n == 65) begin
                check("b2b_show9_an",  {24'd0, an},  32'hFE);
                check("b2b_show9_seg", {25'd0, seg}, 32'h10);
            end
            valid_result = (n == 7) || (n == 12) || (n == 16);
            result = (n == 7) ? 16'sd7 : (n == 12) ? 16'sd8 : 16'sd9;
        end
        valid_result = 1'b0;
        check("b2b_busy_cont", {31'd0, busy_ok}, 32'd1);
        check("b2b_never8",    {31'd0, saw8},    32'd0);

        // Most negative value: magnitude 32768 without overflow.
        start_conv(-16'sd32768);
        repeat (20) @(negedge clk);
        exp_d = '{7'h00, 7'h02, 7'h78, 7'h24, 7'h30, 7'h3F, 7'h7F, 7'h7F};
        check_all("min");

        start_conv(16'sd32767);
        repeat (20) @(negedge clk);
        exp_d = '{7'h78, 7'h02, 7'h78, 7'h24, 7'h30, 7'h7F, 7'h7F, 7'h7F};
        check_all("max");

        // Sticky error hides later results.
        @(negedge clk); error = 1'b1;
        @(negedge clk); error = 1'b0;
        start_conv(16'sd55);
        repeat (20) @(negedge clk);
        exp_d = '{7'h2F, 7'h2F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        check_all("err");

        halt = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            check($sformatf("halt_dp_%0d", n), {31'd0, dp}, (an === 8'h7F) ? 32'd0 : 32'd1);
        end
        halt = 1'b0;

        // Asynchronous reset mid-conversion.
        start_conv(16'sd500);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_an",   {24'd0, an},   32'hFF);
        check("arst_seg",  {25'd0, seg},  32'h7F);
        check("arst_dp",   {31'd0, dp},   32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
        exp_d = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        exp_d = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F};
`endif
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
